// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute sequencer for the 4-bit-opcode core.
// Owns the PC and paces instruction fetch. Gates register, tap and memory commits.
// Resolves be/bne/jump, and stalls while data memory is busy.
// Optional feature macro: SEQ_WATCHDOG_EN. When it is defined, a MEM-state timeout aborts the run with err=1.
module instr_sequencer #(
   parameter int PC_W     = 8,
   parameter int START_PC = 0,
   parameter int LAST_PC  = 255,
   parameter int CNT_W    = 16,
   parameter int MEM_TMO  = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             branch,
   input  logic [1:0]       br_type,
   input  logic             eq_flag,
   input  logic [PC_W-1:0]  target,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic [PC_W-1:0]  pc,
   output logic             ir_load,
   output logic             commit_en,
   output logic             mem_en,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [PC_W-1:0] START_V = PC_W'(START_PC);
   localparam logic [PC_W-1:0] LAST_V  = PC_W'(LAST_PC);

   state_t           state_reg, state_next;
   logic [PC_W-1:0]  pc_reg, pc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             err_reg, err_next;
   logic             br_cond;
   logic             taken;
   logic             at_last;
   logic             wd_clr;
   logic             wd_inc;
   logic             wd_expired;

   // Branch resolution: condition selected by the decoder's MUX7 field.
   always_comb begin
      br_cond = 1'b0;
      case (br_type)
         2'd0:    br_cond = eq_flag;
         2'd1:    br_cond = ~eq_flag;
         2'd2:    br_cond = 1'b1;
         default: br_cond = 1'b0;
      endcase
      taken = branch & br_cond;
   end

   assign at_last = (pc_reg == LAST_V);

`ifdef SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(MEM_TMO + 1);
   logic [WD_W-1:0] wd_reg;

   // The watchdog counts MEM cycles spent waiting. It restarts on every MEM entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wd_reg <= '0;
      else if (wd_clr)
         wd_reg <= '0;
      else if (wd_inc)
         wd_reg <= wd_reg + WD_W'(1);
   end

   assign wd_expired = (wd_reg == WD_W'(MEM_TMO - 1));
`else
   logic unused_wd;
   assign unused_wd  = (MEM_TMO > 0) & wd_clr & wd_inc;
   assign wd_expired = 1'b0;
`endif

   // State, PC, cycle counter and error flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         pc_reg    <= START_V;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   // Next-state logic: sequencing, PC update, and a saturating busy-cycle count.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      err_next   = err_reg;
      wd_clr     = 1'b0;
      wd_inc     = 1'b0;
      cnt_next   = cnt_reg;
      if (busy && !(&cnt_reg))
         cnt_next = cnt_reg + CNT_W'(1);

      case (state_reg)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_next = S_FETCH;
               pc_next    = START_V;
               cnt_next   = '0;
               err_next   = 1'b0;
            end
         end
         S_FETCH: begin
            state_next = S_EXEC;
         end
         S_EXEC: begin
            if (mem_req) begin
               // A memory access takes priority over any branch in the same instruction.
               state_next = S_MEM;
               wd_clr     = 1'b1;
            end else if (at_last && !taken) begin
               state_next = S_DONE;
            end else begin
               pc_next    = taken ? target : pc_reg + PC_W'(1);
               state_next = S_FETCH;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               if (at_last) begin
                  state_next = S_DONE;
               end else begin
                  pc_next    = pc_reg + PC_W'(1);
                  state_next = S_FETCH;
               end
            end else if (wd_expired) begin
               state_next = S_DONE;
               err_next   = 1'b1;
            end else begin
               wd_inc = 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign pc        = pc_reg;
   assign cycle_cnt = cnt_reg;
   assign err       = err_reg;
   assign ir_load   = (state_reg == S_FETCH);
   assign mem_en    = (state_reg == S_MEM);
   assign busy      = (state_reg == S_FETCH) || (state_reg == S_EXEC) || (state_reg == S_MEM);
   assign done      = (state_reg == S_DONE);
   assign commit_en = ((state_reg == S_EXEC) && !mem_req) || ((state_reg == S_MEM) && mem_ready);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (LAST_PC=3, MEM_TMO=4). Checks the SEQ_WATCHDOG_EN behaviour when that macro is defined.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        branch;
   logic [1:0]  br_type;
   logic        eq_flag;
   logic [7:0]  target;
   logic        mem_req;
   logic        mem_ready;
   logic [7:0]  pc;
   logic        ir_load;
   logic        commit_en;
   logic        mem_en;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] cycle_cnt;

   int total = 0;
   int bad   = 0;
   int commits;

   instr_sequencer #(
      .PC_W(8), .START_PC(0), .LAST_PC(3), .CNT_W(16), .MEM_TMO(4)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .branch(branch), .br_type(br_type),
      .eq_flag(eq_flag), .target(target), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc(pc), .ir_load(ir_load), .commit_en(commit_en), .mem_en(mem_en),
      .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Executes one non-memory instruction, starting from FETCH. Checks the EXEC commit and the resulting PC.
   task automatic run_instr(input logic br, input logic [1:0] typ, input logic eq,
                            input logic [7:0] tgt, input logic [7:0] exp_pc, input string tag);
      chk({tag, "_fetch_ir"}, ir_load, 1);
      tick();
      branch = br; br_type = typ; eq_flag = eq; target = tgt; mem_req = 1'b0;
      #1;
      chk({tag, "_commit"}, commit_en, 1);
      commits += int'(commit_en);
      tick();
      branch = 1'b0; br_type = 2'd0; eq_flag = 1'b0;
      chk({tag, "_pc"}, pc, exp_pc);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; branch = 1'b0; br_type = 2'd0; eq_flag = 1'b0;
      target = 8'd0; mem_req = 1'b0; mem_ready = 1'b0;
      tick(); tick();
      chk("rst_pc", pc, 0);
      chk("rst_ir_load", ir_load, 0);
      chk("rst_commit", commit_en, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_cnt", cycle_cnt, 0);
      reset = 1'b0;
      tick();
      chk("idle_hold_busy", busy, 0);

      // Four ALU instructions from pc 0 to pc 3. A start pulse arrives mid-run and must be ignored.
      start = 1'b1; tick(); start = 1'b0;
      chk("run_pc0", pc, 0);
      chk("run_busy", busy, 1);
      commits = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) start = 1'b1;
         run_instr(1'b0, 2'd0, 1'b0, 8'd0, (i == 3) ? 8'd3 : 8'(i + 1), "alu");
         start = 1'b0;
      end
      chk("alu_commit_pulses", commits, 4);
      chk("alu_done", done, 1);
      chk("alu_busy", busy, 0);
      chk("alu_cnt", cycle_cnt, 8);
      tick();
      chk("done_hold", done, 1);
      chk("done_pc", pc, 3);
      chk("done_cnt", cycle_cnt, 8);

      // A restart from DONE reloads START_PC and clears the count.
      start = 1'b1; tick(); start = 1'b0;
      chk("restart_pc", pc, 0);
      chk("restart_cnt", cycle_cnt, 0);
      chk("restart_busy", busy, 1);
      chk("restart_done", done, 0);

      // Branch resolution
      run_instr(1'b1, 2'd2, 1'b0, 8'd5,   8'd5,   "jmp5a");
      run_instr(1'b1, 2'd0, 1'b1, 8'd20,  8'd20,  "be_taken");
      run_instr(1'b1, 2'd2, 1'b0, 8'd5,   8'd5,   "jmp5b");
      run_instr(1'b1, 2'd0, 1'b0, 8'd20,  8'd6,   "be_not");
      run_instr(1'b1, 2'd2, 1'b0, 8'd5,   8'd5,   "jmp5c");
      run_instr(1'b1, 2'd1, 1'b0, 8'd20,  8'd20,  "bne_taken");
      run_instr(1'b1, 2'd3, 1'b1, 8'd9,   8'd21,  "never");
      run_instr(1'b1, 2'd1, 1'b1, 8'd30,  8'd22,  "bne_not");
      run_instr(1'b1, 2'd2, 1'b0, 8'd255, 8'd255, "jmp255");
      run_instr(1'b0, 2'd0, 1'b0, 8'd0,   8'd0,   "wrap");
      run_instr(1'b1, 2'd2, 1'b0, 8'd3,   8'd3,   "jmp3");
      run_instr(1'b1, 2'd2, 1'b0, 8'd1,   8'd1,   "last_taken");
      chk("last_taken_busy", busy, 1);
      run_instr(1'b0, 2'd0, 1'b0, 8'd0,   8'd2,   "alu1");

      // Load at pc 2. mem_ready arrives on the third MEM cycle.
      tick();
      mem_req = 1'b1; #1;
      chk("ld_exec_commit", commit_en, 0);
      chk("ld_exec_mem_en", mem_en, 0);
      tick();
      mem_req = 1'b0; mem_ready = 1'b0; #1;
      chk("ld_mem1_en", mem_en, 1);
      chk("ld_mem1_commit", commit_en, 0);
      chk("ld_mem1_pc", pc, 2);
      tick();
      chk("ld_mem2_en", mem_en, 1);
      chk("ld_mem2_commit", commit_en, 0);
      tick();
      mem_ready = 1'b1; #1;
      chk("ld_mem3_en", mem_en, 1);
      chk("ld_mem3_commit", commit_en, 1);
      tick();
      mem_ready = 1'b0;
      chk("ld_next_pc", pc, 3);
      chk("ld_next_mem_en", mem_en, 0);
      chk("ld_next_ir", ir_load, 1);

      // A memory instruction at LAST_PC ends the program once memory completes.
      tick();
      mem_req = 1'b1;
      tick();
      mem_req = 1'b0; mem_ready = 1'b1; #1;
      chk("ldlast_commit", commit_en, 1);
      tick();
      mem_ready = 1'b0;
      chk("ldlast_done", done, 1);
      chk("ldlast_pc", pc, 3);
      chk("ldlast_cnt", cycle_cnt, 34);

      // Memory stall with mem_ready stuck low
      start = 1'b1; tick(); start = 1'b0;
      tick();
      mem_req = 1'b1;
      tick();
      mem_req = 1'b0; mem_ready = 1'b0;
      chk("stall_mem_en", mem_en, 1);
      repeat (4) tick();
      chk("stall_commit", commit_en, 0);
`ifdef SEQ_WATCHDOG_EN
      chk("wd_done", done, 1);
      chk("wd_err", err, 1);
      chk("wd_pc", pc, 0);
      chk("wd_mem_en", mem_en, 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("wd_err_clear", err, 0);
      chk("wd_restart_busy", busy, 1);
`else
      chk("stall_hold_mem", mem_en, 1);
      chk("stall_busy", busy, 1);
      chk("stall_err", err, 0);
      chk("stall_done", done, 0);
      repeat (3) tick();
      chk("stall_hold_mem2", mem_en, 1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("stall_release_pc", pc, 1);
      chk("stall_release_ir", ir_load, 1);
`endif

      // Reset asserted mid-EXEC takes effect immediately.
      tick();
      #1;
      chk("pre_rst_commit", commit_en, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_commit", commit_en, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_pc", pc, 0);
      chk("async_rst_ir", ir_load, 0);
      chk("async_rst_cnt", cycle_cnt, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("post_rst_idle_busy", busy, 0);
      chk("post_rst_idle_done", done, 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("post_rst_start_ir", ir_load, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
